shift_reg_sequencer: RTL and testbench
======================================

Name: shift_reg_sequencer

Overview:
- Command-driven controller that sits directly upstream of the 4-bit universal shift/rotate/load register.
- Accepts one command at a time over a valid/ready handshake.
- Drives the register's enable, mode, direction, parallel data and serial-in pins to perform a timed sequence: one parallel load, then N shift or rotate cycles, or a load only.
- Emits a one-cycle done pulse at the end of each sequence.

Parameters:
DATA_W, 4, width of cmd_data and reg_d; must match the downstream register width.
CNT_W, 3, width of cmd_cnt; sets the maximum shift/rotate count per command (2^CNT_W-1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command (high only in IDLE).
cmd_op  input  2  00 shift, 01 rotate, 10 load only, 11 nop.
cmd_dir  input  1  direction for the shift/rotate phase: 0 toward MSB, 1 toward LSB.
cmd_cnt  input  CNT_W  number of shift/rotate cycles after the load (0..7).
cmd_data  input  DATA_W  word to parallel-load.
cmd_fill  input  1  serial fill bit presented on reg_s_in during shift.
reg_enb  output  1  register enable.
reg_mode  output  2  register mode: 00 shift, 01 rotate, 10 load, 11 hold.
reg_dir  output  1  register direction.
reg_d  output  DATA_W  register parallel data.
reg_s_in  output  1  register serial input.
done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0, captured fields 0. All reg_* outputs take idle values: reg_enb=0, reg_mode=11, reg_dir=0, reg_d=0, reg_s_in=0. done=0. While rst_n is low no handshake completes.
- All outputs decode only from registered state and captured fields. There is no combinational path from any cmd_* input to any output.
- Handshake: a command is accepted at a rising edge where cmd_valid=1 and cmd_ready=1. On acceptance, op, dir, cnt, data and fill are captured. cmd_valid while busy is ignored; the bench holds it until accepted.
- States:
  - IDLE: cmd_ready=1, reg_* idle. On accept: op 00/01/10 -> LOAD; op 11 -> DONE.
  - LOAD (exactly 1 cycle): reg_enb=1, reg_mode=10, reg_d=captured data, reg_dir=0, reg_s_in=0. Next: op 10 or cnt==0 -> DONE; otherwise RUN with counter=cnt.
  - RUN (exactly cnt cycles): reg_enb=1, reg_mode=captured op (00 or 01), reg_dir=captured dir, reg_s_in=captured fill for op 00 and 0 for op 01, reg_d=0. The counter decrements each cycle; when it is 1 at a clock edge -> DONE.
  - DONE (1 cycle): reg_* idle, done=1, cmd_ready=0. Next: IDLE.
- Latency: for a command accepted at edge E0, LOAD spans E0..E1, RUN spans E1..E1+cnt, and done is high during E1+cnt..E2+cnt. The next command can be accepted at the earliest at edge E3+cnt. The mandatory IDLE cycle gives no back-to-back acceptance.
- Counter: CNT_W bits, never wraps. cnt values greater than DATA_W are legal: a shift simply fills further, a rotate wraps inside the register.
- Reset mid-sequence: the state returns to IDLE immediately; reg_enb drops to 0 asynchronously; the in-flight command is discarded and no done pulse is issued.
- done and cmd_ready are never high together.

Test Plan:
- Reset check: assert rst_n=0 mid-RUN -> reg_enb=0, reg_mode=11, done=0 immediately. After release, cmd_ready=1 on the first cycle.
- Shift test: op=00, dir=0, data=1011, fill=0, cnt=4, with the bench register attached. Required: 1 load cycle then 4 shift cycles; register s_out sequence 1,0,1,1; final q=0000; done pulses 6 cycles after acceptance.
- Rotate test: op=01, dir=1, data=0001, cnt=1 -> final q=1000. Then op=01, dir=0, data=1000, cnt=5 -> final q=0001.
- Load-only and zero-count test: op=10, data=0110 -> exactly one reg_enb cycle, q=0110, done 2 cycles after acceptance. op=00 with cnt=0 -> same timing, no shift cycles.
- Nop test: op=11 -> reg_enb never asserts; done pulses on the cycle after acceptance; q is unchanged.
- Handshake test: hold cmd_valid high with two queued commands -> the second is accepted only at the first IDLE edge after done. cmd_ready is 0 throughout LOAD, RUN and DONE.

Source files
------------

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer
//   Command-driven controller placed directly in front of a universal
//   shift/rotate/load register. One command is accepted at a time. Each
//   command becomes a timed sequence: one parallel load, then cnt shift or
//   rotate cycles (or a load only), then a one-cycle done pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command can be accepted (high only in IDLE)
//   cmd_op     00 shift, 01 rotate, 10 load only, 11 nop
//   cmd_dir    shift/rotate direction: 0 toward MSB, 1 toward LSB
//   cmd_cnt    number of shift/rotate cycles after the load
//   cmd_data   word to parallel-load
//   cmd_fill   serial fill bit used during a shift
//   reg_enb    register enable
//   reg_mode   register mode: 00 shift, 01 rotate, 10 load, 11 hold
//   reg_dir    register direction
//   reg_d      register parallel data
//   reg_s_in   register serial input
//   done       one-cycle pulse when a command completes
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready depends only on the state register, never
// on cmd_valid. A command offered while busy is simply not taken; the
// source keeps cmd_valid and its fields stable until the transfer edge.
//
// Every output decodes from the state register and the captured command
// fields only, so there is no combinational path from any cmd_* input to
// any output.

module shift_reg_sequencer #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_fill,
  output logic              reg_enb,
  output logic [1:0]        reg_mode,
  output logic              reg_dir,
  output logic [DATA_W-1:0] reg_d,
  output logic              reg_s_in,
  output logic              done
);

  localparam logic [1:0] OP_SHIFT  = 2'b00;
  localparam logic [1:0] OP_ROTATE = 2'b01;
  localparam logic [1:0] OP_LOAD   = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Kept as a named enum so checkers can bind to the state directly.
  state_t state, state_nxt;

  logic [1:0]        op_q;
  logic              dir_q;
  logic              fill_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  ctr_q;
  logic              accept;

  assign accept = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Captured command fields and the run counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
      cnt_q  <= '0;
      data_q <= '0;
      ctr_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        dir_q  <= cmd_dir;
        fill_q <= cmd_fill;
        cnt_q  <= cmd_cnt;
        data_q <= cmd_data;
      end
      if (state == S_LOAD) begin
        ctr_q <= cnt_q;
      end else if (state == S_RUN && ctr_q != '0) begin
        // Guarded so the counter can never wrap below zero.
        ctr_q <= ctr_q - 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (cmd_op == OP_NOP) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (op_q == OP_LOAD || cnt_q == '0) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A counter value of 1 marks the last shift/rotate cycle.
        if (ctr_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready = 1'b0;
    reg_enb   = 1'b0;
    reg_mode  = MODE_HOLD;
    reg_dir   = 1'b0;
    reg_d     = '0;
    reg_s_in  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end
      S_LOAD: begin
        reg_enb  = 1'b1;
        reg_mode = MODE_LOAD;
        reg_d    = data_q;
      end
      S_RUN: begin
        reg_enb  = 1'b1;
        reg_mode = (op_q == OP_ROTATE) ? OP_ROTATE : OP_SHIFT;
        reg_dir  = dir_q;
        // The fill bit only matters for a shift; a rotate recirculates.
        reg_s_in = (op_q == OP_SHIFT) ? fill_q : 1'b0;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed testbench for shift_reg_sequencer with a behavioural 4-bit
// universal register attached to the reg_* outputs.

module tb_shift_reg_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       cmd_fill;
  logic       reg_enb;
  logic [1:0] reg_mode;
  logic       reg_dir;
  logic [3:0] reg_d;
  logic       reg_s_in;
  logic       done;

  int n_vec;
  int n_err;

  shift_reg_sequencer #(.DATA_W(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dir   (cmd_dir),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .cmd_fill  (cmd_fill),
    .reg_enb   (reg_enb),
    .reg_mode  (reg_mode),
    .reg_dir   (reg_dir),
    .reg_d     (reg_d),
    .reg_s_in  (reg_s_in),
    .done      (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- downstream register model ----------------
  logic [3:0] q;
  logic       s_out;
  initial q = 4'b0000;
  assign s_out = reg_dir ? q[0] : q[3];

  always @(posedge clk) begin
    if (reg_enb) begin
      case (reg_mode)
        2'b00: q <= reg_dir ? {reg_s_in, q[3:1]} : {q[2:0], reg_s_in};
        2'b01: q <= reg_dir ? {q[0], q[3:1]}     : {q[2:0], q[3]};
        2'b10: q <= reg_d;
        default: q <= q;
      endcase
    end
  end

  // ---------------- per-cycle logs ----------------
  logic       enb_log  [0:15];
  logic       done_log [0:15];
  logic       rdy_log  [0:15];
  logic       sout_log [0:15];
  logic       sin_log  [0:15];
  logic       dir_log  [0:15];
  logic [1:0] mode_log [0:15];
  logic [3:0] d_log    [0:15];

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic dir, input logic [2:0] cnt,
                       input logic [3:0] data, input logic fill);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: cmd_ready=%b, required 1 within 20 cycles", cmd_ready);
    end
    cmd_op    = op;
    cmd_dir   = dir;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Cycle k of the log is the clock period that starts k edges after acceptance.
  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      enb_log[k]  = reg_enb;
      done_log[k] = done;
      rdy_log[k]  = cmd_ready;
      sout_log[k] = s_out;
      sin_log[k]  = reg_s_in;
      dir_log[k]  = reg_dir;
      mode_log[k] = reg_mode;
      d_log[k]    = reg_d;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_dir   = 1'b0;
    cmd_cnt   = 3'd0;
    cmd_data  = 4'b0000;
    cmd_fill  = 1'b0;
    #1;
    n_vec++;
    if (reg_enb !== 1'b0 || reg_mode !== 2'b11 || reg_dir !== 1'b0 ||
        reg_d !== 4'b0000 || reg_s_in !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: enb=%b mode=%b dir=%b d=%b s_in=%b done=%b, required 0 11 0 0000 0 0",
               reg_enb, reg_mode, reg_dir, reg_d, reg_s_in, done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    issue(2'b00, 1'b0, 3'd7, 4'b1111, 1'b1);
    watch(3);
    n_vec++;
    if (enb_log[2] !== 1'b1 || mode_log[2] !== 2'b00) begin
      n_err++;
      $display("FAIL midrun_precond: enb=%b mode=%b, required 1 00", enb_log[2], mode_log[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (reg_enb !== 1'b0 || reg_mode !== 2'b11 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset: enb=%b mode=%b done=%b, required 0 11 0", reg_enb, reg_mode, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_release: cmd_ready=%b done=%b, required 1 0", cmd_ready, done);
    end
    watch(10);
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (done_log[k] !== 1'b0 || enb_log[k] !== 1'b0) begin
        n_err++;
        $display("FAIL midrun_discard[%0d]: done=%b enb=%b, required 0 0", k, done_log[k], enb_log[k]);
      end
    end
  endtask

  task automatic test_shift;
    logic [3:0] exp_out;
    logic [1:0] exp_mode;
    exp_out = 4'b1011;
    issue(2'b00, 1'b0, 3'd4, 4'b1011, 1'b0);
    watch(8);
    for (int k = 0; k < 8; k++) begin
      exp_mode = (k == 0) ? 2'b10 : ((k <= 4) ? 2'b00 : 2'b11);
      n_vec++;
      if (enb_log[k] !== (k <= 4) || done_log[k] !== (k == 5) ||
          rdy_log[k] !== (k >= 6) || mode_log[k] !== exp_mode) begin
        n_err++;
        $display("FAIL shift_timing[%0d]: enb=%b done=%b rdy=%b mode=%b, required %b %b %b %b",
                 k, enb_log[k], done_log[k], rdy_log[k], mode_log[k],
                 (k <= 4), (k == 5), (k >= 6), exp_mode);
      end
    end
    n_vec++;
    if (d_log[0] !== 4'b1011) begin
      n_err++;
      $display("FAIL shift_load_data: reg_d=%b, required 1011", d_log[0]);
    end
    for (int k = 1; k <= 4; k++) begin
      n_vec++;
      if (sout_log[k] !== exp_out[4-k] || sin_log[k] !== 1'b0 || dir_log[k] !== 1'b0) begin
        n_err++;
        $display("FAIL shift_sout[%0d]: s_out=%b s_in=%b dir=%b, required %b 0 0",
                 k, sout_log[k], sin_log[k], dir_log[k], exp_out[4-k]);
      end
    end
    n_vec++;
    if (q !== 4'b0000) begin
      n_err++;
      $display("FAIL shift_final_q: q=%b, required 0000", q);
    end
  endtask

  task automatic test_shift_max_count;
    issue(2'b00, 1'b1, 3'd7, 4'b0000, 1'b1);
    watch(10);
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (enb_log[k] !== (k <= 7) || done_log[k] !== (k == 8)) begin
        n_err++;
        $display("FAIL maxcnt_timing[%0d]: enb=%b done=%b, required %b %b",
                 k, enb_log[k], done_log[k], (k <= 7), (k == 8));
      end
    end
    n_vec++;
    if (sin_log[3] !== 1'b1 || dir_log[3] !== 1'b1) begin
      n_err++;
      $display("FAIL maxcnt_fill: s_in=%b dir=%b, required 1 1", sin_log[3], dir_log[3]);
    end
    n_vec++;
    if (q !== 4'b1111) begin
      n_err++;
      $display("FAIL maxcnt_final_q: q=%b, required 1111", q);
    end
  endtask

  task automatic test_rotate;
    issue(2'b01, 1'b1, 3'd1, 4'b0001, 1'b1);
    watch(4);
    n_vec++;
    if (enb_log[1] !== 1'b1 || mode_log[1] !== 2'b01 || dir_log[1] !== 1'b1 ||
        sin_log[1] !== 1'b0 || done_log[2] !== 1'b1 || enb_log[2] !== 1'b0) begin
      n_err++;
      $display("FAIL rot1_timing: enb=%b mode=%b dir=%b s_in=%b done2=%b enb2=%b, required 1 01 1 0 1 0",
               enb_log[1], mode_log[1], dir_log[1], sin_log[1], done_log[2], enb_log[2]);
    end
    n_vec++;
    if (q !== 4'b1000) begin
      n_err++;
      $display("FAIL rot1_final_q: q=%b, required 1000", q);
    end
    issue(2'b01, 1'b0, 3'd5, 4'b1000, 1'b1);
    watch(8);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (enb_log[k] !== (k <= 5) || done_log[k] !== (k == 6)) begin
        n_err++;
        $display("FAIL rot5_timing[%0d]: enb=%b done=%b, required %b %b",
                 k, enb_log[k], done_log[k], (k <= 5), (k == 6));
      end
    end
    n_vec++;
    if (sin_log[3] !== 1'b0 || mode_log[3] !== 2'b01 || dir_log[3] !== 1'b0) begin
      n_err++;
      $display("FAIL rot5_pins: s_in=%b mode=%b dir=%b, required 0 01 0", sin_log[3], mode_log[3], dir_log[3]);
    end
    n_vec++;
    if (q !== 4'b0001) begin
      n_err++;
      $display("FAIL rot5_final_q: q=%b, required 0001", q);
    end
  endtask

  task automatic test_load_only;
    issue(2'b10, 1'b1, 3'd5, 4'b0110, 1'b1);
    watch(4);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (enb_log[k] !== (k == 0) || done_log[k] !== (k == 1)) begin
        n_err++;
        $display("FAIL load_timing[%0d]: enb=%b done=%b, required %b %b",
                 k, enb_log[k], done_log[k], (k == 0), (k == 1));
      end
    end
    n_vec++;
    if (q !== 4'b0110) begin
      n_err++;
      $display("FAIL load_final_q: q=%b, required 0110", q);
    end
    issue(2'b00, 1'b0, 3'd0, 4'b1001, 1'b1);
    watch(4);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (enb_log[k] !== (k == 0) || done_log[k] !== (k == 1)) begin
        n_err++;
        $display("FAIL zerocnt_timing[%0d]: enb=%b done=%b, required %b %b",
                 k, enb_log[k], done_log[k], (k == 0), (k == 1));
      end
    end
    n_vec++;
    if (q !== 4'b1001) begin
      n_err++;
      $display("FAIL zerocnt_final_q: q=%b, required 1001", q);
    end
  endtask

  task automatic test_nop;
    issue(2'b11, 1'b1, 3'd3, 4'b1111, 1'b1);
    watch(4);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (enb_log[k] !== 1'b0 || done_log[k] !== (k == 0) || rdy_log[k] !== (k >= 1)) begin
        n_err++;
        $display("FAIL nop_timing[%0d]: enb=%b done=%b rdy=%b, required 0 %b %b",
                 k, enb_log[k], done_log[k], rdy_log[k], (k == 0), (k >= 1));
      end
    end
    n_vec++;
    if (q !== 4'b1001) begin
      n_err++;
      $display("FAIL nop_q_unchanged: q=%b, required 1001", q);
    end
  endtask

  task automatic test_back_to_back;
    int acc;
    int k;
    @(negedge clk);
    cmd_op    = 2'b10;
    cmd_dir   = 1'b0;
    cmd_cnt   = 3'd0;
    cmd_data  = 4'b0011;
    cmd_fill  = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    // First command taken here; the second one is queued behind it.
    #1 cmd_data = 4'b1100;
    acc = -1;
    k = 0;
    while (acc < 0 && k < 12) begin
      @(negedge clk);
      rdy_log[k]  = cmd_ready;
      done_log[k] = done;
      if (cmd_ready) acc = k + 1;
      k++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n_vec++;
    if (acc != 3) begin
      n_err++;
      $display("FAIL b2b_accept_edge: accepted at edge %0d, required 3", acc);
    end
    n_vec++;
    if (rdy_log[0] !== 1'b0 || rdy_log[1] !== 1'b0 || done_log[1] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_busy: rdy0=%b rdy1=%b done1=%b, required 0 0 1", rdy_log[0], rdy_log[1], done_log[1]);
    end
    watch(4);
    n_vec++;
    if (enb_log[0] !== 1'b1 || d_log[0] !== 4'b1100 || done_log[1] !== 1'b1 || rdy_log[1] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: enb=%b d=%b done=%b rdy=%b, required 1 1100 1 0",
               enb_log[0], d_log[0], done_log[1], rdy_log[1]);
    end
    n_vec++;
    if (q !== 4'b1100) begin
      n_err++;
      $display("FAIL b2b_final_q: q=%b, required 1100", q);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_shift;
    test_rotate;
    test_load_only;
    test_nop;
    test_shift_max_count;
    test_back_to_back;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
